// File: rtl/axi_arb_pkg.sv
// axi_arb_pkg: shared state encodings and constants for the two-master AXI arbiter
package axi_arb_pkg;
    typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} rd_state_e;
    typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA, W_RESP} wr_state_e;
    localparam logic MST0 = 1'b0;
    localparam logic MST1 = 1'b1;
    localparam logic [1:0] RESP_OKAY = 2'b00;
endpackage

// File: rtl/axi_slave_arbiter_rr2.sv
// arb_rr2: two-request round-robin arbiter with a registered grant
// Ports: clk/rst; req[1:0] requests (bit n = master n); load captures the
// winner into gnt; done marks end of the granted burst and advances the pointer.
module arb_rr2
    import axi_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       load,
    input  logic       done,
    output logic       gnt
);
    logic ptr;
    logic win;
    // a lone requester wins outright; the pointer only breaks ties
    assign win = (req == 2'b01) ? MST0 : (req == 2'b10) ? MST1 : ptr;
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= MST0;
            gnt <= MST0;
        end else begin
            if (load) gnt <= win;
            if (done) ptr <= ~gnt;
        end
    end
endmodule

// File: rtl/axi_slave_arbiter.sv
// axi_slave_arbiter: shares one AXI slave between two DMA masters, read and write arbitrated independently
// Ports: clk/rst; M0_AXI_*/M1_AXI_* slave-side AR/R/AW/W/B channels per master;
// S_AXI_* master-side channels toward the shared slave. Pure router, no data buffering.
module axi_slave_arbiter
    import axi_arb_pkg::*;
#(
    parameter int ADDR_WD = 32,
    parameter int DATA_WD = 32,
    localparam int STRB_WD = DATA_WD / 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               M0_AXI_ARVALID,
    input  logic [ADDR_WD-1:0] M0_AXI_ARADDR,
    input  logic [ADDR_WD-1:0] M0_AXI_ARLEN,
    input  logic [2:0]         M0_AXI_ARSIZE,
    input  logic [1:0]         M0_AXI_ARBURST,
    output logic               M0_AXI_ARREADY,
    output logic               M0_AXI_RVALID,
    output logic [DATA_WD-1:0] M0_AXI_RDATA,
    output logic [1:0]         M0_AXI_RRESP,
    output logic               M0_AXI_RLAST,
    input  logic               M0_AXI_RREADY,
    input  logic               M0_AXI_AWVALID,
    input  logic [ADDR_WD-1:0] M0_AXI_AWADDR,
    input  logic [ADDR_WD-1:0] M0_AXI_AWLEN,
    input  logic [2:0]         M0_AXI_AWSIZE,
    input  logic [1:0]         M0_AXI_AWBURST,
    output logic               M0_AXI_AWREADY,
    input  logic               M0_AXI_WVALID,
    input  logic [DATA_WD-1:0] M0_AXI_WDATA,
    input  logic [STRB_WD-1:0] M0_AXI_WSTRB,
    input  logic               M0_AXI_WLAST,
    output logic               M0_AXI_WREADY,
    output logic               M0_AXI_BVALID,
    output logic [1:0]         M0_AXI_BRESP,
    input  logic               M0_AXI_BREADY,
    input  logic               M1_AXI_ARVALID,
    input  logic [ADDR_WD-1:0] M1_AXI_ARADDR,
    input  logic [ADDR_WD-1:0] M1_AXI_ARLEN,
    input  logic [2:0]         M1_AXI_ARSIZE,
    input  logic [1:0]         M1_AXI_ARBURST,
    output logic               M1_AXI_ARREADY,
    output logic               M1_AXI_RVALID,
    output logic [DATA_WD-1:0] M1_AXI_RDATA,
    output logic [1:0]         M1_AXI_RRESP,
    output logic               M1_AXI_RLAST,
    input  logic               M1_AXI_RREADY,
    input  logic               M1_AXI_AWVALID,
    input  logic [ADDR_WD-1:0] M1_AXI_AWADDR,
    input  logic [ADDR_WD-1:0] M1_AXI_AWLEN,
    input  logic [2:0]         M1_AXI_AWSIZE,
    input  logic [1:0]         M1_AXI_AWBURST,
    output logic               M1_AXI_AWREADY,
    input  logic               M1_AXI_WVALID,
    input  logic [DATA_WD-1:0] M1_AXI_WDATA,
    input  logic [STRB_WD-1:0] M1_AXI_WSTRB,
    input  logic               M1_AXI_WLAST,
    output logic               M1_AXI_WREADY,
    output logic               M1_AXI_BVALID,
    output logic [1:0]         M1_AXI_BRESP,
    input  logic               M1_AXI_BREADY,
    output logic               S_AXI_ARVALID,
    output logic [ADDR_WD-1:0] S_AXI_ARADDR,
    output logic [ADDR_WD-1:0] S_AXI_ARLEN,
    output logic [2:0]         S_AXI_ARSIZE,
    output logic [1:0]         S_AXI_ARBURST,
    input  logic               S_AXI_ARREADY,
    input  logic               S_AXI_RVALID,
    input  logic [DATA_WD-1:0] S_AXI_RDATA,
    input  logic [1:0]         S_AXI_RRESP,
    input  logic               S_AXI_RLAST,
    output logic               S_AXI_RREADY,
    output logic               S_AXI_AWVALID,
    output logic [ADDR_WD-1:0] S_AXI_AWADDR,
    output logic [ADDR_WD-1:0] S_AXI_AWLEN,
    output logic [2:0]         S_AXI_AWSIZE,
    output logic [1:0]         S_AXI_AWBURST,
    input  logic               S_AXI_AWREADY,
    output logic               S_AXI_WVALID,
    output logic [DATA_WD-1:0] S_AXI_WDATA,
    output logic [STRB_WD-1:0] S_AXI_WSTRB,
    output logic               S_AXI_WLAST,
    input  logic               S_AXI_WREADY,
    input  logic               S_AXI_BVALID,
    input  logic [1:0]         S_AXI_BRESP,
    output logic               S_AXI_BREADY
);
    rd_state_e rs, rs_n;
    wr_state_e ws, ws_n;
    logic rg, wg;
    logic ra, rd, wa, wd, wb;
    logic r_end, w_end, b_end;
    assign ra = rs == R_ADDR;
    assign rd = rs == R_DATA;
    assign wa = ws == W_ADDR;
    assign wd = ws == W_DATA;
    assign wb = ws == W_RESP;
    // the forwarded ready/valid are already gated to their state, so these only fire in it
    assign r_end = S_AXI_RVALID & S_AXI_RREADY & S_AXI_RLAST;
    assign w_end = S_AXI_WVALID & S_AXI_WREADY & S_AXI_WLAST;
    assign b_end = S_AXI_BVALID & S_AXI_BREADY;
    arb_rr2 u_rd_arb (
        .clk  (clk),
        .rst  (rst),
        .req  ({M1_AXI_ARVALID, M0_AXI_ARVALID}),
        .load (rs == R_IDLE),
        .done (r_end),
        .gnt  (rg)
    );
    arb_rr2 u_wr_arb (
        .clk  (clk),
        .rst  (rst),
        .req  ({M1_AXI_AWVALID, M0_AXI_AWVALID}),
        .load (ws == W_IDLE),
        .done (b_end),
        .gnt  (wg)
    );
    always_ff @(posedge clk) begin
        if (rst) begin
            rs <= R_IDLE;
            ws <= W_IDLE;
        end else begin
            rs <= rs_n;
            ws <= ws_n;
        end
    end
    always_comb begin
        rs_n = (rs == R_IDLE && (M0_AXI_ARVALID || M1_AXI_ARVALID)) ? R_ADDR :
               (ra && S_AXI_ARVALID && S_AXI_ARREADY) ? R_DATA :
               r_end ? R_IDLE : rs;
        ws_n = (ws == W_IDLE && (M0_AXI_AWVALID || M1_AXI_AWVALID)) ? W_ADDR :
               (wa && S_AXI_AWVALID && S_AXI_AWREADY) ? W_DATA :
               w_end ? W_RESP :
               b_end ? W_IDLE : ws;
    end
    assign S_AXI_ARVALID  = ra & (rg ? M1_AXI_ARVALID : M0_AXI_ARVALID);
    assign S_AXI_ARADDR   = ra ? (rg ? M1_AXI_ARADDR : M0_AXI_ARADDR) : '0;
    assign S_AXI_ARLEN    = ra ? (rg ? M1_AXI_ARLEN : M0_AXI_ARLEN) : '0;
    assign S_AXI_ARSIZE   = ra ? (rg ? M1_AXI_ARSIZE : M0_AXI_ARSIZE) : '0;
    assign S_AXI_ARBURST  = ra ? (rg ? M1_AXI_ARBURST : M0_AXI_ARBURST) : '0;
    assign M0_AXI_ARREADY = ra & ~rg & S_AXI_ARREADY;
    assign M1_AXI_ARREADY = ra & rg & S_AXI_ARREADY;
    assign S_AXI_RREADY   = rd & (rg ? M1_AXI_RREADY : M0_AXI_RREADY);
    assign M0_AXI_RVALID  = rd & ~rg & S_AXI_RVALID;
    assign M1_AXI_RVALID  = rd & rg & S_AXI_RVALID;
    assign M0_AXI_RLAST   = rd & ~rg & S_AXI_RLAST;
    assign M1_AXI_RLAST   = rd & rg & S_AXI_RLAST;
    assign M0_AXI_RDATA   = rd ? S_AXI_RDATA : '0;
    assign M1_AXI_RDATA   = rd ? S_AXI_RDATA : '0;
    assign M0_AXI_RRESP   = rd ? S_AXI_RRESP : RESP_OKAY;
    assign M1_AXI_RRESP   = rd ? S_AXI_RRESP : RESP_OKAY;
    assign S_AXI_AWVALID  = wa & (wg ? M1_AXI_AWVALID : M0_AXI_AWVALID);
    assign S_AXI_AWADDR   = wa ? (wg ? M1_AXI_AWADDR : M0_AXI_AWADDR) : '0;
    assign S_AXI_AWLEN    = wa ? (wg ? M1_AXI_AWLEN : M0_AXI_AWLEN) : '0;
    assign S_AXI_AWSIZE   = wa ? (wg ? M1_AXI_AWSIZE : M0_AXI_AWSIZE) : '0;
    assign S_AXI_AWBURST  = wa ? (wg ? M1_AXI_AWBURST : M0_AXI_AWBURST) : '0;
    assign M0_AXI_AWREADY = wa & ~wg & S_AXI_AWREADY;
    assign M1_AXI_AWREADY = wa & wg & S_AXI_AWREADY;
    assign S_AXI_WVALID   = wd & (wg ? M1_AXI_WVALID : M0_AXI_WVALID);
    assign S_AXI_WDATA    = wd ? (wg ? M1_AXI_WDATA : M0_AXI_WDATA) : '0;
    assign S_AXI_WSTRB    = wd ? (wg ? M1_AXI_WSTRB : M0_AXI_WSTRB) : '0;
    assign S_AXI_WLAST    = wd & (wg ? M1_AXI_WLAST : M0_AXI_WLAST);
    assign M0_AXI_WREADY  = wd & ~wg & S_AXI_WREADY;
    assign M1_AXI_WREADY  = wd & wg & S_AXI_WREADY;
    assign S_AXI_BREADY   = wb & (wg ? M1_AXI_BREADY : M0_AXI_BREADY);
    assign M0_AXI_BVALID  = wb & ~wg & S_AXI_BVALID;
    assign M1_AXI_BVALID  = wb & wg & S_AXI_BVALID;
    assign M0_AXI_BRESP   = wb ? S_AXI_BRESP : RESP_OKAY;
    assign M1_AXI_BRESP   = wb ? S_AXI_BRESP : RESP_OKAY;
endmodule

// File: tb/tb_axi_slave_arbiter.sv
// tb_axi_slave_arbiter: directed bench with a word-addressed behavioural slave (mem[a] = a at start)
module tb_axi_slave_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    logic [1:0] arvalid, arready, rvalid, rready, rlast, awvalid, awready;
    logic [1:0] wvalid, wready, wlast, bvalid, bready;
    logic [31:0] araddr [2], arlen [2], rdata [2], awaddr [2], awlen [2], wdata [2];
    logic [2:0] arsize [2], awsize [2];
    logic [1:0] arburst [2], awburst [2], rresp [2], bresp [2];
    logic [3:0] wstrb [2];
    logic s_arvalid, s_arready, s_rvalid, s_rlast, s_rready, s_awvalid, s_awready;
    logic s_wvalid, s_wlast, s_wready, s_bvalid, s_bready;
    logic [31:0] s_araddr, s_arlen, s_rdata, s_awaddr, s_awlen, s_wdata;
    logic [2:0] s_arsize, s_awsize;
    logic [1:0] s_arburst, s_awburst, s_rresp, s_bresp;
    logic [3:0] s_wstrb;
    int total = 0;
    int bad = 0;
    int cyc = 0;
    logic [31:0] rbuf [2][16];
    logic lastbuf [2][16];
    logic [31:0] ar_addr_log [8];
    int ar_cyc_log [8];
    int rl_log [8];
    int n_ar = 0;
    int n_rl = 0;

    axi_slave_arbiter dut (
        .clk(clk), .rst(rst),
        .M0_AXI_ARVALID(arvalid[0]), .M0_AXI_ARADDR(araddr[0]), .M0_AXI_ARLEN(arlen[0]),
        .M0_AXI_ARSIZE(arsize[0]), .M0_AXI_ARBURST(arburst[0]), .M0_AXI_ARREADY(arready[0]),
        .M0_AXI_RVALID(rvalid[0]), .M0_AXI_RDATA(rdata[0]), .M0_AXI_RRESP(rresp[0]),
        .M0_AXI_RLAST(rlast[0]), .M0_AXI_RREADY(rready[0]),
        .M0_AXI_AWVALID(awvalid[0]), .M0_AXI_AWADDR(awaddr[0]), .M0_AXI_AWLEN(awlen[0]),
        .M0_AXI_AWSIZE(awsize[0]), .M0_AXI_AWBURST(awburst[0]), .M0_AXI_AWREADY(awready[0]),
        .M0_AXI_WVALID(wvalid[0]), .M0_AXI_WDATA(wdata[0]), .M0_AXI_WSTRB(wstrb[0]),
        .M0_AXI_WLAST(wlast[0]), .M0_AXI_WREADY(wready[0]),
        .M0_AXI_BVALID(bvalid[0]), .M0_AXI_BRESP(bresp[0]), .M0_AXI_BREADY(bready[0]),
        .M1_AXI_ARVALID(arvalid[1]), .M1_AXI_ARADDR(araddr[1]), .M1_AXI_ARLEN(arlen[1]),
        .M1_AXI_ARSIZE(arsize[1]), .M1_AXI_ARBURST(arburst[1]), .M1_AXI_ARREADY(arready[1]),
        .M1_AXI_RVALID(rvalid[1]), .M1_AXI_RDATA(rdata[1]), .M1_AXI_RRESP(rresp[1]),
        .M1_AXI_RLAST(rlast[1]), .M1_AXI_RREADY(rready[1]),
        .M1_AXI_AWVALID(awvalid[1]), .M1_AXI_AWADDR(awaddr[1]), .M1_AXI_AWLEN(awlen[1]),
        .M1_AXI_AWSIZE(awsize[1]), .M1_AXI_AWBURST(awburst[1]), .M1_AXI_AWREADY(awready[1]),
        .M1_AXI_WVALID(wvalid[1]), .M1_AXI_WDATA(wdata[1]), .M1_AXI_WSTRB(wstrb[1]),
        .M1_AXI_WLAST(wlast[1]), .M1_AXI_WREADY(wready[1]),
        .M1_AXI_BVALID(bvalid[1]), .M1_AXI_BRESP(bresp[1]), .M1_AXI_BREADY(bready[1]),
        .S_AXI_ARVALID(s_arvalid), .S_AXI_ARADDR(s_araddr), .S_AXI_ARLEN(s_arlen),
        .S_AXI_ARSIZE(s_arsize), .S_AXI_ARBURST(s_arburst), .S_AXI_ARREADY(s_arready),
        .S_AXI_RVALID(s_rvalid), .S_AXI_RDATA(s_rdata), .S_AXI_RRESP(s_rresp),
        .S_AXI_RLAST(s_rlast), .S_AXI_RREADY(s_rready),
        .S_AXI_AWVALID(s_awvalid), .S_AXI_AWADDR(s_awaddr), .S_AXI_AWLEN(s_awlen),
        .S_AXI_AWSIZE(s_awsize), .S_AXI_AWBURST(s_awburst), .S_AXI_AWREADY(s_awready),
        .S_AXI_WVALID(s_wvalid), .S_AXI_WDATA(s_wdata), .S_AXI_WSTRB(s_wstrb),
        .S_AXI_WLAST(s_wlast), .S_AXI_WREADY(s_wready),
        .S_AXI_BVALID(s_bvalid), .S_AXI_BRESP(s_bresp), .S_AXI_BREADY(s_bready)
    );

    // behavioural slave: one beat per cycle, ready whenever idle
    logic [31:0] mem [256];
    logic rbusy, wbusy, bpend;
    logic [31:0] rptr, rcnt, wptr;
    initial for (int i = 0; i < 256; i++) mem[i] = i;
    assign s_arready = !rbusy;
    assign s_rvalid  = rbusy;
    assign s_rdata   = mem[rptr[7:0]];
    assign s_rresp   = 2'b00;
    assign s_rlast   = rbusy && rcnt == 0;
    assign s_awready = !wbusy && !bpend;
    assign s_wready  = wbusy;
    assign s_bvalid  = bpend;
    assign s_bresp   = 2'b00;
    always @(posedge clk) begin
        if (rst) begin
            rbusy <= 0; wbusy <= 0; bpend <= 0; rptr <= 0; rcnt <= 0; wptr <= 0;
        end else begin
            if (s_arvalid && s_arready) begin
                rbusy <= 1; rptr <= s_araddr; rcnt <= s_arlen;
            end else if (s_rvalid && s_rready) begin
                rptr <= rptr + 1; rcnt <= rcnt - 1;
                if (s_rlast) rbusy <= 0;
            end
            if (s_awvalid && s_awready) begin
                wbusy <= 1; wptr <= s_awaddr;
            end else if (s_wvalid && s_wready) begin
                for (int i = 0; i < 4; i++) if (s_wstrb[i]) mem[wptr[7:0]][8*i +: 8] <= s_wdata[8*i +: 8];
                wptr <= wptr + 1;
                if (s_wlast) begin wbusy <= 0; bpend <= 1; end
            end
            if (s_bvalid && s_bready) bpend <= 0;
        end
    end

    always @(posedge clk) cyc <= cyc + 1;
    // sampled just after the falling edge, i.e. the values the next rising edge will see
    always @(negedge clk) begin
        #1;
        if (s_arvalid && s_arready && n_ar < 8) begin
            ar_addr_log[n_ar] = s_araddr; ar_cyc_log[n_ar] = cyc; n_ar++;
        end
        if (s_rvalid && s_rready && s_rlast && n_rl < 8) begin
            rl_log[n_rl] = cyc; n_rl++;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    task automatic do_reset();
        rst = 1;
        arvalid = 0; rready = 0; awvalid = 0; wvalid = 0; wlast = 0; bready = 0;
        for (int m = 0; m < 2; m++) begin
            araddr[m] = 0; arlen[m] = 0; arsize[m] = 0; arburst[m] = 0;
            awaddr[m] = 0; awlen[m] = 0; awsize[m] = 0; awburst[m] = 0; wdata[m] = 0; wstrb[m] = 0;
        end
        repeat (2) @(negedge clk);
        rst = 0;
        n_ar = 0; n_rl = 0;
    endtask

    task automatic rd(input int m, input logic [31:0] a, input logic [31:0] n, output int got, output bit to);
        int k;
        bit fin;
        got = 0; to = 0; fin = 0; k = 0;
        araddr[m] = a; arlen[m] = n; arsize[m] = 3'd2; arburst[m] = 2'b01; arvalid[m] = 1'b1;
        while (!arready[m] && k < 60) begin @(negedge clk); k++; end
        @(negedge clk);
        arvalid[m] = 1'b0;
        if (k == 60) begin to = 1; return; end
        rready[m] = 1'b1;
        while (!fin && !to) begin
            k = 0;
            while (!rvalid[m] && k < 60) begin @(negedge clk); k++; end
            if (k == 60) to = 1;
            else begin
                rbuf[m][got] = rdata[m]; lastbuf[m][got] = rlast[m];
                fin = rlast[m] || got == 15;
                got++;
                @(negedge clk);
            end
        end
        rready[m] = 1'b0;
    endtask

    task automatic wr(input int m, input logic [31:0] a, input logic [31:0] n, input logic [31:0] d0,
                      input logic [31:0] d1, input int bdly, output bit to, output logic [1:0] resp);
        int k;
        to = 0; resp = 2'b11; k = 0;
        awaddr[m] = a; awlen[m] = n; awsize[m] = 3'd2; awburst[m] = 2'b01; awvalid[m] = 1'b1;
        while (!awready[m] && k < 60) begin @(negedge clk); k++; end
        @(negedge clk);
        awvalid[m] = 1'b0;
        if (k == 60) begin to = 1; return; end
        for (int i = 0; i <= int'(n) && !to; i++) begin
            wdata[m] = (i == 0) ? d0 : d1; wstrb[m] = 4'hF; wlast[m] = (i == int'(n)); wvalid[m] = 1'b1; k = 0;
            while (!wready[m] && k < 60) begin @(negedge clk); k++; end
            if (k == 60) to = 1;
            else @(negedge clk);
        end
        wvalid[m] = 1'b0; wlast[m] = 1'b0;
        if (to) return;
        k = 0;
        while (!bvalid[m] && k < 60) begin @(negedge clk); k++; end
        if (k == 60) begin to = 1; return; end
        repeat (bdly) @(negedge clk);
        bready[m] = 1'b1; resp = bresp[m];
        @(negedge clk);
        bready[m] = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        araddr[0] = 32'hDEAD_BEEF; wdata[1] = 32'h1234_5678;
        @(negedge clk);
        total++;
        if ({arready, rvalid, rlast, awready, wready, bvalid, rresp[0], rresp[1], bresp[0], bresp[1],
             s_arvalid, s_rready, s_awvalid, s_wvalid, s_wlast, s_bready} !== '0) begin
            bad++; $display("FAIL reset_handshakes: some handshake output nonzero, required all 0");
        end
        total++;
        if ((rdata[0] | rdata[1] | s_araddr | s_awaddr | s_wdata) !== 32'h0) begin
            bad++; $display("FAIL reset_data: got rdata0=%h rdata1=%h s_araddr=%h s_wdata=%h, required 0",
                            rdata[0], rdata[1], s_araddr, s_wdata);
        end
        araddr[0] = 0; wdata[1] = 0;
    endtask

    task automatic test_single_read();
        int got;
        bit to, m1_seen, done;
        do_reset();
        m1_seen = 0; done = 0;
        fork
            begin rd(0, 32'h10, 32'd3, got, to); done = 1; end
            begin
                for (int k = 0; k < 100 && !done; k++) begin
                    @(negedge clk); #1;
                    if (rvalid[1] || rlast[1]) m1_seen = 1;
                end
            end
        join
        total++;
        if (to || got != 4) begin bad++; $display("FAIL single_read_beats: got %0d beats timeout=%0d, required 4", got, to); end
        for (int i = 0; i < 4; i++) begin
            total++;
            if (rbuf[0][i] !== 32'h10 + i) begin
                bad++; $display("FAIL single_read_data%0d: got %h, required %h", i, rbuf[0][i], 32'h10 + i);
            end
        end
        total++;
        if ({lastbuf[0][3], lastbuf[0][2], lastbuf[0][1], lastbuf[0][0]} !== 4'b1000) begin
            bad++; $display("FAIL single_read_rlast: got %b, required 1000",
                            {lastbuf[0][3], lastbuf[0][2], lastbuf[0][1], lastbuf[0][0]});
        end
        total++;
        if (m1_seen !== 1'b0) begin bad++; $display("FAIL single_read_m1_quiet: M1 saw RVALID/RLAST=1, required 0"); end
        total++;
        if ({s_arvalid, s_rready, arready} !== 4'b0) begin
            bad++; $display("FAIL single_read_idle: got arvalid=%b rready=%b arready=%b, required 0", s_arvalid, s_rready, arready);
        end
    endtask

    task automatic test_round_robin();
        int g0, g1;
        bit t0, t1;
        do_reset();
        fork
            rd(0, 32'h40, 32'd3, g0, t0);
            rd(1, 32'h80, 32'd1, g1, t1);
        join
        total++;
        if (t0 || t1 || n_ar != 2) begin bad++; $display("FAIL rr_pair_done: timeouts %0d/%0d ar count %0d, required 0/0/2", t0, t1, n_ar); end
        total++;
        if (ar_addr_log[0] !== 32'h40 || ar_addr_log[1] !== 32'h80) begin
            bad++; $display("FAIL rr_first_order: got %h then %h, required 00000040 then 00000080", ar_addr_log[0], ar_addr_log[1]);
        end
        total++;
        if (ar_cyc_log[1] - rl_log[0] != 2) begin
            bad++; $display("FAIL rr_gap: M1 AR %0d cycles after M0 RLAST, required 2", ar_cyc_log[1] - rl_log[0]);
        end
        total++;
        if (rbuf[1][0] !== 32'h80 || rbuf[1][1] !== 32'h81) begin
            bad++; $display("FAIL rr_m1_data: got %h %h, required 00000080 00000081", rbuf[1][0], rbuf[1][1]);
        end
        rd(0, 32'h44, 32'd0, g0, t0);
        n_ar = 0;
        fork
            rd(0, 32'h48, 32'd0, g0, t0);
            rd(1, 32'h88, 32'd0, g1, t1);
        join
        total++;
        if (ar_addr_log[0] !== 32'h88 || n_ar != 2) begin
            bad++; $display("FAIL rr_second_order: first AR %h count %0d, required 00000088 count 2", ar_addr_log[0], n_ar);
        end
    endtask

    task automatic test_concurrent();
        int g0;
        bit t0, t1;
        logic [1:0] resp;
        do_reset();
        fork
            rd(0, 32'h30, 32'd3, g0, t0);
            wr(1, 32'h20, 32'd1, 32'hA5A5_A5A5, 32'h5A5A_5A5A, 0, t1, resp);
        join
        total++;
        if (t0 || t1 || g0 != 4) begin bad++; $display("FAIL conc_done: rd timeout %0d wr timeout %0d beats %0d, required 0 0 4", t0, t1, g0); end
        total++;
        if (resp !== 2'b00) begin bad++; $display("FAIL conc_bresp: got %b, required 00", resp); end
        total++;
        if (rbuf[0][0] !== 32'h30 || rbuf[0][3] !== 32'h33) begin
            bad++; $display("FAIL conc_rdata: got %h..%h, required 00000030..00000033", rbuf[0][0], rbuf[0][3]);
        end
        rd(0, 32'h20, 32'd1, g0, t0);
        total++;
        if (t0 || rbuf[0][0] !== 32'hA5A5_A5A5 || rbuf[0][1] !== 32'h5A5A_5A5A) begin
            bad++; $display("FAIL conc_readback: got %h %h, required a5a5a5a5 5a5a5a5a", rbuf[0][0], rbuf[0][1]);
        end
    endtask

    task automatic test_bready_stall();
        bit t0, t1, m0_done, seen_rdy1;
        logic [1:0] r0, r1;
        int hold;
        int g;
        bit tr;
        do_reset();
        m0_done = 0; seen_rdy1 = 0; hold = 0;
        fork
            begin wr(0, 32'h50, 32'd1, 32'h11, 32'h22, 5, t0, r0); m0_done = 1; end
            begin repeat (3) @(negedge clk); wr(1, 32'h60, 32'd0, 32'h33, 32'h0, 0, t1, r1); end
            begin
                for (int k = 0; k < 200 && !m0_done; k++) begin
                    @(negedge clk); #1;
                    if (awready[1]) seen_rdy1 = 1;
                    if (bvalid[0] && !bready[0]) hold++;
                end
            end
        join
        total++;
        if (hold != 5) begin bad++; $display("FAIL stall_bvalid_hold: BVALID held %0d cycles, required 5", hold); end
        total++;
        if (seen_rdy1 !== 1'b0) begin bad++; $display("FAIL stall_m1_awready: M1 AWREADY=1 before M0 B, required 0"); end
        total++;
        if (t0 || t1 || r0 !== 2'b00 || r1 !== 2'b00) begin
            bad++; $display("FAIL stall_complete: timeouts %0d/%0d resp %b/%b, required 0/0 00/00", t0, t1, r0, r1);
        end
        rd(1, 32'h60, 32'd0, g, tr);
        total++;
        if (tr || rbuf[1][0] !== 32'h33) begin bad++; $display("FAIL stall_m1_data: got %h, required 00000033", rbuf[1][0]); end
    endtask

    task automatic test_reset_mid();
        int k;
        do_reset();
        araddr[0] = 32'h10; arlen[0] = 32'd3; arsize[0] = 3'd2; arburst[0] = 2'b01; arvalid[0] = 1;
        k = 0;
        while (!arready[0] && k < 20) begin @(negedge clk); k++; end
        @(negedge clk);
        arvalid[0] = 0; rready[0] = 1;
        @(negedge clk);
        total++;
        if (rvalid[0] !== 1'b1 || rdata[0] !== 32'h11) begin
            bad++; $display("FAIL mid_beat2: rvalid=%b rdata=%h, required 1 00000011", rvalid[0], rdata[0]);
        end
        rst = 1;
        @(negedge clk);
        total++;
        if ({arready, rvalid, rlast, awready, wready, bvalid, rresp[0], rresp[1], bresp[0], bresp[1],
             s_arvalid, s_rready, s_awvalid, s_wvalid, s_wlast, s_bready} !== '0 || (rdata[0] | rdata[1]) !== 32'h0) begin
            bad++; $display("FAIL mid_reset_outputs: rvalid=%b rready_s=%b rdata0=%h, required all 0", rvalid, s_rready, rdata[0]);
        end
        rst = 0; rready[0] = 0;
        araddr[1] = 32'h90; arlen[1] = 32'd0; arsize[1] = 3'd2; arburst[1] = 2'b01; arvalid[1] = 1;
        @(negedge clk);
        total++;
        if (arready[1] !== 1'b1 || s_araddr !== 32'h90) begin
            bad++; $display("FAIL mid_regrant: arready1=%b s_araddr=%h, required 1 00000090", arready[1], s_araddr);
        end
        @(negedge clk);
        arvalid[1] = 0; rready[1] = 1;
        total++;
        if (rvalid[1] !== 1'b1 || rlast[1] !== 1'b1 || rdata[1] !== 32'h90) begin
            bad++; $display("FAIL mid_m1_beat: rvalid=%b rlast=%b rdata=%h, required 1 1 00000090", rvalid[1], rlast[1], rdata[1]);
        end
        @(negedge clk);
        rready[1] = 0;
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_round_robin();
        test_concurrent();
        test_bready_stall();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
